// File: rtl/pipeline_hold_ctrl_pkg.sv
// Shared types for the pipeline hold controller: controller state encoding
// and default statistics counter width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipeline_hold_ctrl_if.sv
// Request/control bundle between the hold controller (master) and the
// pipeline registers plus hazard logic (slave).
import pipe_ctrl_pkg::*;

interface pipeline_hold_ctrl_if #(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic             load_stall;
    logic             branch_taken;
    logic             mem_busy;
    logic             halt_req;
    logic             resume;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_en;
    logic             memwb_bubble;
    logic             halted;
    logic             stall_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  load_stall, branch_taken, mem_busy, halt_req, resume,
        output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
               memwb_bubble, halted, stall_err, stall_cnt, flush_cnt
    );

    modport slave (
        output load_stall, branch_taken, mem_busy, halt_req, resume,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
               memwb_bubble, halted, stall_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hold_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipeline_hold_ctrl.sv
// Converts stall / flush / memory-wait / halt requests into per-stage enables
// for a 5-stage pipeline. Statistics counters exist only with PIPE_PERF_CNT_EN.
import pipe_ctrl_pkg::*;

module pipeline_hold_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_STALL    = 3,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hold_ctrl_if.master bus
);
    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int RUN_W   = $clog2(MAX_STALL + 2);

    state_t               state_reg, state_next;
    logic [DRAIN_W-1:0]   drain_reg, drain_next;
    logic                 halt_pend_reg, halt_pend_next;
    logic                 stall_err_reg;
    logic [RUN_W-1:0]     run_cnt;

    logic take_stall;
    logic take_flush;
    logic stall_hit;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            drain_reg     <= '0;
            halt_pend_reg <= 1'b0;
            stall_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_reg     <= drain_next;
            halt_pend_reg <= halt_pend_next;
            stall_err_reg <= stall_err_reg | stall_hit;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_next     = drain_reg;
        halt_pend_next = halt_pend_reg;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        exmem_en       = 1'b1;
        memwb_bubble   = 1'b0;
        take_stall     = 1'b0;
        take_flush     = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (bus.mem_busy) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    // A halt arriving during a freeze waits for the first free cycle.
                    if (bus.halt_req) halt_pend_next = 1'b1;
                end else begin
                    if (bus.branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        take_flush  = 1'b1;
                    end else if (bus.load_stall) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        take_stall  = 1'b1;
                    end
                    if (bus.halt_req || halt_pend_reg) begin
                        state_next     = DRAIN;
                        drain_next     = DRAIN_W'(DRAIN_CYCLES);
                        halt_pend_next = 1'b0;
                    end
                end
            end
            DRAIN: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                if (bus.mem_busy) begin
                    ifid_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end else if (drain_reg <= DRAIN_W'(1)) begin
                    state_next = HALTED;
                    drain_next = '0;
                end else begin
                    drain_next = drain_reg - DRAIN_W'(1);
                end
            end
            HALTED: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_bubble  = 1'b1;
                memwb_bubble = 1'b1;
                if (bus.resume) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // The flag shows up in the same cycle as the offending stall, then sticks.
    assign stall_hit = take_stall && (run_cnt >= RUN_W'(MAX_STALL));

    sat_counter #(.WIDTH(RUN_W)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_stall && (run_cnt <= RUN_W'(MAX_STALL))),
        .clear (!take_stall),
        .count (run_cnt)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [1:0]       stat_inc;
    logic [CNT_W-1:0] stat_cnt [2];

    assign stat_inc = {take_flush, take_stall};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        sat_counter #(.WIDTH(CNT_W)) u_stat (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (stat_inc[gi]),
            .clear (1'b0),
            .count (stat_cnt[gi])
        );
    end

    assign bus.stall_cnt = stat_cnt[0];
    assign bus.flush_cnt = stat_cnt[1];
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.halted       = (state_reg == HALTED);
    assign bus.stall_err    = stall_err_reg | stall_hit;
endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Directed bench for pipeline_hold_ctrl (DRAIN_CYCLES=4, MAX_STALL=3, CNT_W=4).
module tb_pipeline_hold_ctrl;
    localparam int CW = 4;

    // Output vector order: pc_en ifid_en ifid_flush idex_bubble exmem_en memwb_bubble halted
    localparam logic [6:0] O_RUN    = 7'b1100100;
    localparam logic [6:0] O_MEM    = 7'b0000010;
    localparam logic [6:0] O_BRANCH = 7'b1111100;
    localparam logic [6:0] O_STALL  = 7'b0001100;
    localparam logic [6:0] O_DRAIN  = 7'b0110100;
    localparam logic [6:0] O_DRBUSY = 7'b0010010;
    localparam logic [6:0] O_HALTED = 7'b0001111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    pipeline_hold_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hold_ctrl #(
        .DRAIN_CYCLES (4),
        .MAX_STALL    (3),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
                bus.exmem_en, bus.memwb_bubble, bus.halted};
    endfunction

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef PIPE_PERF_CNT_EN
        return (v > 15) ? 32'd15 : 32'(v);
`else
        return (v > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ls, input logic bt, input logic mb,
                         input logic hr, input logic rs);
        bus.load_stall   = ls;
        bus.branch_taken = bt;
        bus.mem_busy     = mb;
        bus.halt_req     = hr;
        bus.resume       = rs;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        chk("reset_outs", 32'(outs()), 32'(O_RUN));
        chk("reset_err", 32'(bus.stall_err), 32'd0);
        chk("reset_scnt", 32'(bus.stall_cnt), 32'd0);
        chk("reset_fcnt", 32'(bus.flush_cnt), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single load-use stall
        drive(1, 0, 0, 0, 0);
        chk("ld_stall_outs", 32'(outs()), 32'(O_STALL));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("ld_after_outs", 32'(outs()), 32'(O_RUN));
        chk("ld_scnt", 32'(bus.stall_cnt), cnt_exp(1));
        chk("ld_err", 32'(bus.stall_err), 32'd0);

        // Branch wins over simultaneous load stall
        drive(1, 1, 0, 0, 0);
        chk("br_outs", 32'(outs()), 32'(O_BRANCH));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("br_fcnt", 32'(bus.flush_cnt), cnt_exp(1));
        chk("br_scnt", 32'(bus.stall_cnt), cnt_exp(1));

        // Memory freeze masks everything
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0);
            chk("mem_outs", 32'(outs()), 32'(O_MEM));
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        chk("mem_fcnt", 32'(bus.flush_cnt), cnt_exp(1));
        chk("mem_scnt", 32'(bus.stall_cnt), cnt_exp(1));

        // Halt: four drain cycles then halted
        drive(0, 0, 0, 1, 0);
        chk("halt_req_cycle", 32'(outs()), 32'(O_RUN));
        cyc();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_outs", 32'(outs()), 32'(O_DRAIN));
            cyc();
        end
        chk("halted_outs", 32'(outs()), 32'(O_HALTED));
        drive(0, 0, 0, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("halted_ignore_halt", 32'(outs()), 32'(O_HALTED));
        drive(0, 0, 0, 0, 1);
        chk("resume_cycle", 32'(outs()), 32'(O_HALTED));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("resume_run", 32'(outs()), 32'(O_RUN));

        // Resume outside HALTED is ignored
        drive(0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("resume_in_run", 32'(outs()), 32'(O_RUN));

        // Halt with two memory-busy cycles -> six drain cycles, branch ignored
        drive(0, 0, 0, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("drb_c1", 32'(outs()), 32'(O_DRAIN));
        cyc();
        drive(0, 0, 1, 0, 0);
        chk("drb_c2", 32'(outs()), 32'(O_DRBUSY));
        cyc();
        chk("drb_c3", 32'(outs()), 32'(O_DRBUSY));
        cyc();
        drive(0, 1, 0, 0, 0);
        chk("drb_c4_branch", 32'(outs()), 32'(O_DRAIN));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("drb_fcnt", 32'(bus.flush_cnt), cnt_exp(1));
        chk("drb_c5", 32'(outs()), 32'(O_DRAIN));
        cyc();
        chk("drb_c6", 32'(outs()), 32'(O_DRAIN));
        cyc();
        chk("drb_halted", 32'(outs()), 32'(O_HALTED));
        drive(0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("drb_resume", 32'(outs()), 32'(O_RUN));

        // Three-cycle stall burst leaves stall_err clear
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            chk("burst3_err", 32'(bus.stall_err), 32'd0);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        chk("burst3_after", 32'(bus.stall_err), 32'd0);
        cyc();

        // Four-cycle burst trips it on the fourth cycle, then it sticks
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0);
            chk("burst4_err", 32'(bus.stall_err), (i == 3) ? 32'd1 : 32'd0);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        chk("burst4_sticky", 32'(bus.stall_err), 32'd1);
        chk("burst_scnt", 32'(bus.stall_cnt), cnt_exp(8));
        cyc();
        chk("burst4_sticky2", 32'(bus.stall_err), 32'd1);

        // Twenty branch flushes saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0, 0);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        chk("sat_fcnt", 32'(bus.flush_cnt), cnt_exp(21));

        // Halt latched during memory wait, taken on first free cycle
        drive(0, 0, 1, 1, 0);
        chk("pend_mem", 32'(outs()), 32'(O_MEM));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("pend_run", 32'(outs()), 32'(O_RUN));
        cyc();
        chk("pend_drain", 32'(outs()), 32'(O_DRAIN));
        cyc();

        // Reset mid-DRAIN
        rst_n = 1'b0;
        #1;
        chk("rst_drain_outs", 32'(outs()), 32'(O_RUN));
        chk("rst_drain_err", 32'(bus.stall_err), 32'd0);
        chk("rst_drain_scnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_drain_fcnt", 32'(bus.flush_cnt), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_run1", 32'(outs()), 32'(O_RUN));
        cyc();
        chk("rst_run2", 32'(outs()), 32'(O_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_hold_ctrl.md
Name: pipeline_hold_ctrl

Overview:
- Consumer of the load-use stall request from hazard detection; converts stall, branch-flush, data-memory-wait and halt requests into per-stage enables and bubble/flush controls for the 5-stage pipeline.
- Tracks halt-drain sequencing, flags a stuck stall, and keeps saturating stall/flush statistics.
- Sits in the top-level CPU next to the hazard and forwarding logic; drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- DRAIN_CYCLES, 4, cycles held in DRAIN after a halt request before entering HALTED.
- MAX_STALL, 3, consecutive load_stall cycles tolerated before stall_err is set.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_stall  in  1  load-use stall request from hazard detection (combinational, same cycle).
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- halt_req  in  1  single-cycle pulse requesting halt.
- resume  in  1  single-cycle pulse that leaves HALTED.
- pc_en  out  1  PC register write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_en  out  1  EX/MEM register enable.
- memwb_bubble  out  1  load NOP into MEM/WB.
- halted  out  1  state is HALTED.
- stall_err  out  1  sticky stuck-stall flag.
- stall_cnt  out  CNT_W  load-stall cycles, saturating.
- flush_cnt  out  CNT_W  branch flushes, saturating.

Behaviour:
- Reset value of every output:
  - Asynchronous reset gives state RUN, run counter 0, stall_err 0, counters 0.
  - Combinational outputs during reset: pc_en 1, ifid_en 1, ifid_flush 0, idex_bubble 0, exmem_en 1, memwb_bubble 0, halted 0.
- States: RUN, DRAIN, HALTED. Outputs are combinational from the registered state and the current inputs (zero latency); state changes on the clock edge.
- RUN, decided in priority order:
  1. mem_busy=1: pc_en=0, ifid_en=0, idex_bubble=0, exmem_en=0, memwb_bubble=1. All other requests are ignored this cycle.
  2. branch_taken=1: pc_en=1, ifid_flush=1, idex_bubble=1. A simultaneous load_stall is discarded because the stalled instruction is squashed. flush_cnt increments by 1.
  3. load_stall=1: pc_en=0, ifid_en=0, idex_bubble=1. stall_cnt increments by 1.
  4. Otherwise: all enables 1, no bubbles.
- halt_req in RUN:
  - Load the drain counter with DRAIN_CYCLES and move to DRAIN, unless mem_busy=1.
  - A halt_req during mem_busy is latched as pending and acted on in the first cycle with mem_busy=0.
- DRAIN:
  - pc_en=0 and ifid_flush=1 every cycle; downstream stages advance unless mem_busy=1.
  - The counter decrements only when mem_busy=0. Go to HALTED when it reaches 0.
  - branch_taken is ignored, since the flushed front end holds no live branch.
- HALTED:
  - pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1, memwb_bubble=1; halted=1.
  - resume returns to RUN next cycle; halt_req is ignored.
- resume outside HALTED is ignored.
- Stuck-stall check:
  - The run counter counts consecutive RUN cycles that take rule 3. It clears on any other cycle and saturates at MAX_STALL+1.
  - On the cycle it would exceed MAX_STALL, stall_err=1. stall_err stays set until reset.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-DRAIN or in HALTED returns immediately to RUN and clears any pending halt.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt are implemented as above.
- Undefined: both are tied to 0, with no counter flops; all other behaviour is unchanged.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state enum (RUN, DRAIN, HALTED) and the default CNT_W.
- One natural sub-module: sat_counter (parameter width, inputs inc and clear, saturating output), instantiated for stall_cnt, flush_cnt and the run counter.

Test Plan:
- Single load-use: load_stall=1 for 1 cycle in RUN -> that cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle all enables 1; stall_cnt=1; stall_err=0.
- Branch over stall: branch_taken=1 and load_stall=1 together -> ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- Memory freeze: mem_busy=1 for 3 cycles with load_stall=1 and branch_taken=1 -> pc_en/ifid_en/exmem_en=0, memwb_bubble=1 all 3 cycles; both counters remain 0.
- Halt/resume, DRAIN_CYCLES=4:
  - halt_req pulse -> exactly 4 DRAIN cycles with pc_en=0, then halted=1.
  - mem_busy=1 for 2 of those cycles -> 6 DRAIN cycles.
  - resume -> RUN next cycle.
- Stuck stall, MAX_STALL=3: load_stall high 4 consecutive cycles -> stall_err=1 on the 4th cycle and stays set afterwards; a 3-cycle burst leaves it 0.
- Saturation and reset:
  - CNT_W=4 with 20 branch flushes -> flush_cnt=15.
  - rst_n low while in DRAIN -> RUN, counters 0.
